// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
package sram_arbiter_pkg;

    localparam int   AW      = 32;
    localparam int   DW      = 32;
    localparam int   MW      = DW / 8;
    localparam logic RST_ACT = 1'b0;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One latched SRAM access; a fetch carries we=0 and wmask=0.
    typedef struct packed {
        logic          port;
        logic [AW-1:0] addr;
        logic          we;
        logic [MW-1:0] wmask;
        logic [DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/arb_starve_prio.sv
// Data-over-fetch fixed priority with a cap on consecutive data grants
// taken while a fetch is waiting.
module arb_starve_prio
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic d_valid,
    input  logic fire,
    output logic winner
);

    localparam int CW = $clog2(MAX_DATA_BURST + 1);

    logic [CW-1:0] starve_cnt;

    // Data wins unless it has already used up its burst over a pending fetch.
    always_comb begin
        winner = PORT_I;
        if (d_valid && ((starve_cnt < CW'(MAX_DATA_BURST)) || !i_valid))
            winner = PORT_D;
    end

    // Count data grants that bypassed a waiting fetch; any other grant clears it.
    always_ff @(posedge clk) begin
        if (reset == RST_ACT) begin
            starve_cnt <= '0;
        end else if (fire) begin
            if (winner == PORT_D && i_valid)
                starve_cnt <= starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Serializes fetch and load/store accesses onto one single-port SRAM.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int SRAM_LAT       = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [AW-1:0] i_addr,
    output logic          i_resp_valid,
    input  logic          i_resp_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [MW-1:0] d_wmask,
    input  logic [DW-1:0] d_wdata,
    output logic          d_resp_valid,
    input  logic          d_resp_ready,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] addr,
    output logic          en,
    output logic          we,
    output logic [MW-1:0] wmask,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata
);

    localparam int LCW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

    state_t         state;
    req_t           req;
    req_t           nreq;
    logic [LCW-1:0] lat_cnt;
    logic [DW-1:0]  resp_data;
    logic           winner;
    logic           idle;
    logic           fire;

    assign idle        = (state == IDLE);
    assign i_req_ready = idle && i_req_valid && (winner == PORT_I);
    assign d_req_ready = idle && d_req_valid && (winner == PORT_D);
    assign fire        = i_req_ready || d_req_ready;

    // Address and write payload stay on the SRAM pins for the whole access.
    assign addr    = req.addr;
    assign wmask   = req.wmask;
    assign wdata   = req.wdata;
    assign i_rdata = resp_data;
    assign d_rdata = resp_data;

    arb_starve_prio #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_prio (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .fire    (fire),
        .winner  (winner)
    );

    // Pick the winner's request fields; a fetch never writes.
    always_comb begin
        nreq      = '0;
        nreq.port = winner;
        if (winner == PORT_D) begin
            nreq.addr  = d_addr;
            nreq.we    = d_we;
            nreq.wmask = d_wmask;
            nreq.wdata = d_wdata;
        end else begin
            nreq.addr  = i_addr;
        end
    end

    // IDLE -> ACCESS (en pulses once) -> RESP (held until the consumer takes it).
    always_ff @(posedge clk) begin
        if (reset == RST_ACT) begin
            state        <= IDLE;
            req          <= '0;
            lat_cnt      <= '0;
            resp_data    <= '0;
            en           <= 1'b0;
            we           <= 1'b0;
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        req     <= nreq;
                        lat_cnt <= '0;
                        en      <= 1'b1;
                        we      <= nreq.we;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    en      <= 1'b0;
                    we      <= 1'b0;
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LCW'(SRAM_LAT - 1)) begin
                        resp_data    <= req.we ? '0 : rdata;
                        i_resp_valid <= (req.port == PORT_I);
                        d_resp_valid <= (req.port == PORT_D);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if ((i_resp_valid && i_resp_ready) || (d_resp_valid && d_resp_ready)) begin
                        i_resp_valid <= 1'b0;
                        d_resp_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a transaction-level reference model.
module tb_sram_arbiter;

    localparam int LAT  = 1;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
    logic [31:0] i_addr, i_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wmask;
    logic [31:0] addr, wdata, rdata;
    logic        en, we;
    logic [3:0]  wmask;

    logic        t3_reset;
    logic        t3_i_req_valid, t3_i_req_ready, t3_i_resp_valid, t3_i_resp_ready;
    logic [31:0] t3_i_addr, t3_i_rdata;
    logic        t3_d_req_valid, t3_d_req_ready, t3_d_we, t3_d_resp_valid, t3_d_resp_ready;
    logic [31:0] t3_d_addr, t3_d_wdata, t3_d_rdata;
    logic [3:0]  t3_d_wmask;
    logic [31:0] t3_addr, t3_wdata, t3_rdata;
    logic        t3_en, t3_we;
    logic [3:0]  t3_wmask;

    logic [31:0] mem  [64];
    logic [31:0] mmem [64];
    int          checks = 0;
    int          errors = 0;
    string       glog = "";
    bit          log_en = 1'b0;

    sram_arbiter #(.SRAM_LAT(LAT), .MAX_DATA_BURST(MAXB)) u_dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_rdata(d_rdata),
        .addr(addr), .en(en), .we(we), .wmask(wmask), .wdata(wdata), .rdata(rdata)
    );

    sram_arbiter #(.SRAM_LAT(3), .MAX_DATA_BURST(MAXB)) u_dut3 (
        .clk(clk), .reset(t3_reset),
        .i_req_valid(t3_i_req_valid), .i_req_ready(t3_i_req_ready), .i_addr(t3_i_addr),
        .i_resp_valid(t3_i_resp_valid), .i_resp_ready(t3_i_resp_ready), .i_rdata(t3_i_rdata),
        .d_req_valid(t3_d_req_valid), .d_req_ready(t3_d_req_ready), .d_addr(t3_d_addr),
        .d_we(t3_d_we), .d_wmask(t3_d_wmask), .d_wdata(t3_d_wdata),
        .d_resp_valid(t3_d_resp_valid), .d_resp_ready(t3_d_resp_ready), .d_rdata(t3_d_rdata),
        .addr(t3_addr), .en(t3_en), .we(t3_we), .wmask(t3_wmask), .wdata(t3_wdata), .rdata(t3_rdata)
    );

    // SRAM behavioural model: read data follows the held address, writes on en&we.
    assign rdata    = mem[addr[7:2]];
    assign t3_rdata = mem[t3_addr[7:2]];

    always @(posedge clk) begin
        if (en && we)
            for (int b = 0; b < 4; b++)
                if (wmask[b]) mem[addr[7:2]][b*8 +: 8] <= wdata[b*8 +: 8];
    end

    always @(negedge clk) begin
        if (log_en && d_req_valid && d_req_ready) glog = {glog, "D"};
        if (log_en && i_req_valid && i_req_ready) glog = {glog, "I"};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one access in flight; age counts cycles since the grant.
    initial begin : model
        bit          busy, gd, gst, wd, e_ir, e_dr, e_rv;
        int          age, streak;
        logic [31:0] ga, gw, ed;
        logic [3:0]  gm;
        busy = 0; gd = 0; gst = 0; age = 0; streak = 0;
        ga = 0; gw = 0; ed = 0; gm = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            wd   = d_req_valid && (streak < MAXB || !i_req_valid);
            e_dr = !busy && wd;
            e_ir = !busy && i_req_valid && !wd;
            e_rv = busy && (age >= 1 + LAT);
            chk("m_i_req_ready", i_req_ready, e_ir);
            chk("m_d_req_ready", d_req_ready, e_dr);
            chk("m_en", en, busy && age == 1);
            chk("m_we", we, busy && age == 1 && gst);
            chk("m_i_resp_valid", i_resp_valid, e_rv && !gd);
            chk("m_d_resp_valid", d_resp_valid, e_rv && gd);
            if (busy && age <= LAT) begin
                chk("m_addr", addr, ga);
                chk("m_wmask", wmask, gm);
                if (gd) chk("m_wdata", wdata, gw);
            end
            if (e_rv) chk(gd ? "m_d_rdata" : "m_i_rdata", gd ? d_rdata : i_rdata, ed);
            if (!reset) begin
                busy = 0; streak = 0;
            end else if (!busy) begin
                if (e_dr || e_ir) begin
                    busy = 1; age = 1; gd = e_dr;
                    if (e_dr) begin
                        ga = d_addr; gst = d_we; gm = d_wmask; gw = d_wdata;
                        streak = i_req_valid ? streak + 1 : 0;
                    end else begin
                        ga = i_addr; gst = 0; gm = 0; gw = 0; streak = 0;
                    end
                    ed = gst ? 32'h0 : mmem[ga[7:2]];
                    if (gst)
                        for (int b = 0; b < 4; b++)
                            if (gm[b]) mmem[ga[7:2]][b*8 +: 8] = gw[b*8 +: 8];
                end
            end else if (age >= 1 + LAT && (gd ? d_resp_ready : i_resp_ready)) begin
                busy = 0;
            end else begin
                age++;
            end
        end
    end

    // Single load or fetch with bounded waits; returns the response word.
    task automatic access(input bit dport, input logic [31:0] a, output logic [31:0] rd);
        int n;
        i_resp_ready = 1; d_resp_ready = 1;
        if (dport) begin
            d_addr = a; d_we = 0; d_wmask = 0; d_wdata = 0; d_req_valid = 1;
        end else begin
            i_addr = a; i_req_valid = 1;
        end
        n = 0;
        @(negedge clk);
        while (!(dport ? d_req_ready : i_req_ready) && n < 20) begin @(negedge clk); n++; end
        chk("grant_wait", 32'(n < 20), 32'd1);
        tick();
        if (dport) d_req_valid = 0; else i_req_valid = 0;
        n = 0;
        @(negedge clk);
        while (!(dport ? d_resp_valid : i_resp_valid) && n < 20) begin @(negedge clk); n++; end
        chk("resp_wait", 32'(n < 20), 32'd1);
        rd = dport ? d_rdata : i_rdata;
        tick();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        int          bad;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0101_0101 * k;
        mem[0] = 32'h1234_5678; mem[3] = 32'h0BAD_CAFE;
        mem[4] = 32'hDEAD_BEEF; mem[8] = 32'hCAFE_F00D;
        for (int k = 0; k < 64; k++) mmem[k] = mem[k];
        reset = 0; t3_reset = 0;
        i_req_valid = 0; i_addr = 0; i_resp_ready = 1;
        d_req_valid = 0; d_addr = 0; d_we = 0; d_wmask = 0; d_wdata = 0; d_resp_ready = 1;
        t3_i_req_valid = 0; t3_i_addr = 0; t3_i_resp_ready = 1;
        t3_d_req_valid = 0; t3_d_addr = 0; t3_d_we = 0; t3_d_wmask = 0; t3_d_wdata = 0;
        t3_d_resp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", en, 0); chk("rst_we", we, 0); chk("rst_addr", addr, 0);
        chk("rst_wmask", wmask, 0); chk("rst_wdata", wdata, 0);
        chk("rst_i_resp_valid", i_resp_valid, 0); chk("rst_d_resp_valid", d_resp_valid, 0);
        tick();
        reset = 1; t3_reset = 1;
        tick();

        // Fetch with the default one-cycle SRAM.
        i_addr = 32'h8000_0000; i_req_valid = 1;
        @(negedge clk); chk("t1_i_req_ready", i_req_ready, 1);
        tick(); i_req_valid = 0;
        @(negedge clk);
        chk("t1_en", en, 1); chk("t1_we", we, 0); chk("t1_wmask", wmask, 0);
        chk("t1_addr", addr, 32'h8000_0000); chk("t1_resp_early", i_resp_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_en_off", en, 0); chk("t1_i_resp_valid", i_resp_valid, 1);
        chk("t1_i_rdata", i_rdata, 32'h1234_5678);
        tick();

        // Simultaneous requests: data first, fetch right after the data handshake.
        i_addr = 32'h04; d_addr = 32'h08; d_we = 0; i_req_valid = 1; d_req_valid = 1;
        @(negedge clk);
        chk("t2_d_req_ready", d_req_ready, 1); chk("t2_i_req_ready", i_req_ready, 0);
        tick(); d_req_valid = 0;
        tick();
        @(negedge clk);
        chk("t2_d_resp_valid", d_resp_valid, 1); chk("t2_d_rdata", d_rdata, 32'h0202_0202);
        chk("t2_i_wait", i_req_ready, 0);
        tick();
        @(negedge clk); chk("t2_i_grant", i_req_ready, 1);
        tick(); i_req_valid = 0;
        repeat (3) tick();

        // Starvation limit with both requesters always valid.
        glog = ""; log_en = 1;
        i_addr = 32'h0C; d_addr = 32'h14; d_we = 0; i_req_valid = 1; d_req_valid = 1;
        for (int k = 0; k < 80 && glog.len() < 10; k++) tick();
        i_req_valid = 0; d_req_valid = 0; log_en = 0;
        checks++;
        if (glog != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL t3_grant_order actual=%s expected=DDDDIDDDDI", glog);
        end
        repeat (4) tick();

        // Masked store, then read back the merged word.
        d_addr = 32'h10; d_we = 1; d_wmask = 4'b0100; d_wdata = 32'h00AB_0000; d_req_valid = 1;
        @(negedge clk); chk("t4_d_req_ready", d_req_ready, 1);
        tick(); d_req_valid = 0; d_we = 0;
        @(negedge clk);
        chk("t4_en", en, 1); chk("t4_we", we, 1); chk("t4_wmask", wmask, 32'h4);
        chk("t4_wdata", wdata, 32'h00AB_0000); chk("t4_addr", addr, 32'h10);
        tick();
        @(negedge clk);
        chk("t4_en_off", en, 0); chk("t4_we_off", we, 0);
        chk("t4_d_resp_valid", d_resp_valid, 1); chk("t4_d_rdata", d_rdata, 0);
        tick();
        access(1'b1, 32'h10, rd);
        chk("t4_readback", rd, 32'hDEAB_BEEF);

        // Data consumer stalls; fetch must wait until the response is taken.
        d_addr = 32'h20; d_we = 0; d_resp_ready = 0; d_req_valid = 1;
        i_addr = 32'h00; i_req_valid = 1;
        @(negedge clk); chk("t5_d_req_ready", d_req_ready, 1);
        tick(); d_req_valid = 0;
        tick();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (d_resp_valid !== 1'b1 || d_rdata !== 32'hCAFE_F00D || en !== 1'b0 || i_req_ready !== 1'b0)
                bad++;
            tick();
        end
        chk("t5_stall_hold", bad, 0);
        d_resp_ready = 1;
        @(negedge clk); chk("t5_d_resp_valid", d_resp_valid, 1);
        tick();
        @(negedge clk); chk("t5_i_grant", i_req_ready, 1); chk("t5_d_resp_done", d_resp_valid, 0);
        tick(); i_req_valid = 0;
        repeat (3) tick();
        access(1'b0, 32'h80, rd);
        chk("t5_fetch_after", rd, 32'h2020_2020);

        // Three-cycle SRAM: response four cycles after the grant.
        t3_d_addr = 32'h0C; t3_d_req_valid = 1;
        @(negedge clk); chk("t6_ready", t3_d_req_ready, 1);
        tick(); t3_d_req_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("t6_no_resp_T%0d", k), t3_d_resp_valid, 0);
            chk($sformatf("t6_en_T%0d", k), t3_en, (k == 1) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk("t6_we", t3_we, 0); chk("t6_wmask", t3_wmask, 0); chk("t6_wdata", t3_wdata, 0);
            end
            tick();
        end
        @(negedge clk);
        chk("t6_resp_T4", t3_d_resp_valid, 1); chk("t6_rdata", t3_d_rdata, 32'h0BAD_CAFE);
        chk("t6_i_quiet", t3_i_resp_valid, 0); chk("t6_i_ready", t3_i_req_ready, 0);
        tick();

        // Reset during ACCESS discards the load.
        t3_d_addr = 32'h0C; t3_d_req_valid = 1;
        @(negedge clk); chk("t6r_ready", t3_d_req_ready, 1);
        tick(); t3_d_req_valid = 0; t3_reset = 0;
        @(negedge clk); chk("t6r_en", t3_en, 1);
        tick(); t3_reset = 1;
        @(negedge clk);
        chk("t6r_en_off", t3_en, 0); chk("t6r_d_resp", t3_d_resp_valid, 0);
        chk("t6r_i_resp", t3_i_resp_valid, 0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            if (t3_d_resp_valid !== 1'b0 || t3_i_resp_valid !== 1'b0) bad++;
        end
        chk("t6r_no_resp", bad, 0);
        tick();
        t3_d_addr = 32'h00; t3_d_req_valid = 1;
        @(negedge clk); chk("t6r_idle_ready", t3_d_req_ready, 1);
        tick(); t3_d_req_valid = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("t6r_fresh_resp", t3_d_resp_valid, 1); chk("t6r_fresh_rdata", t3_d_rdata, 32'h1234_5678);
        tick();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
